mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port. It sequences each access through issue, wait and response, and returns per-port read data with a one-cycle done pulse. It drives per-port stall signals that freeze the pipeline registers. It also drops in-flight fetches on a branch flush, so it sits between the IF/MEM stages and the unified memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en_o cycle to valid mem_rdata_i; legal range 1..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word; valid when if_done_o=1, held otherwise
- if_done_o  out  1  one-cycle completion pulse
- if_stall_o  out  1  if_req_i & ~if_done_o
- flush_i  in  1  branch flush; cancels the in-flight fetch
- dm_req_i, dm_we_i  in  1  data request / write enable; held until dm_done_o
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data; updated on read completions only
- dm_done_o  out  1  one-cycle completion pulse (reads and writes)
- dm_stall_o  out  1  dm_req_i & ~dm_done_o
- mem_en_o, mem_we_o  out  1  memory command strobe / write enable, one cycle per access
- mem_addr_o, mem_wdata_o  out  ADDR_W / DATA_W  command address / write data, registered
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  state != IDLE
- owner_o  out  1  port of the current or last transaction: 0 = IF, 1 = DM

## Operation
- States: IDLE, ISSUE, WAIT, DONE; counter lat_cnt is 4 bits.
- Grant decision in IDLE and DONE:
  - DM has priority over IF, because the older instruction goes first.
  - In DONE, the port just completed is ignored: its req is stale.
  - Result: back-to-back requesters alternate, and no port starves.
- IDLE: on a grant, latch owner_o, addr, we and wdata; go to ISSUE. Otherwise stay.
- ISSUE: mem_en_o=1; mem_we_o = we when owner is DM, else 0; load lat_cnt=MEM_LAT; go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==1, capture mem_rdata_i into the owner's rdata register. Capture only on reads, and for IF only when the transaction is not killed. Then go to DONE.
- DONE:
  - Pulse the owner's done_o, unless the transaction is an IF one marked killed.
  - Arbitrate the other port. On a grant go to ISSUE, else go to IDLE.
- Flush:
  - flush_i=1 while IF owns a transaction in ISSUE or WAIT sets a kill flag.
  - The memory access still runs to completion, so arbiter timing is unchanged.
  - The kill flag clears on entry to the next ISSUE.
- Flush boundaries:
  - flush_i during DONE has no effect; the registered pulse is already committed.
  - flush_i has no effect when DM owns the transaction or the arbiter is IDLE.
- Writes return dm_done_o with dm_rdata_o unchanged.
- No queuing: at most one transaction is outstanding.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, lat_cnt 0, kill 0.
  - if_rdata_o and dm_rdata_o are cleared to 0.
- Uncontended latency: req sampled in cycle t gives mem_en_o at t+1, mem_rdata_i valid at t+1+MEM_LAT, done_o at t+2+MEM_LAT.
- Back-to-back handoff: DONE of one port and the grant of the other share a cycle. The next mem_en_o follows one cycle later.
- Reset mid-transaction: return to IDLE immediately. No done pulse; the late mem_rdata_i is ignored.
- if_stall_o and dm_stall_o are combinational from registered done and input req; no other combinational input-to-output paths.

## Test plan
- MEM_LAT=2, IF read alone:
  - Stimulus: if_req_i at cycle 0, if_addr_i=0x40; mem_rdata_i=0x2002000A at cycle 3.
  - Response: mem_en_o at 1 with mem_addr_o=0x40; if_done_o at 4 with if_rdata_o=0x2002000A; if_stall_o 1 in cycles 0–3.
- Both ports request at cycle 0, DM read at 0x10:
  - Response: DM mem_en_o at 1, dm_done_o at 4. IF granted in cycle 4, mem_en_o at 5, if_done_o at 8.
- DM write, dm_addr_i=0x8, dm_wdata_i=0xDEADBEEF:
  - Response: mem_en_o=mem_we_o=1 at cycle 1 with those values; dm_done_o at 4; dm_rdata_o stays at its prior value.
- IF fetch with flush_i at cycle 2:
  - Response: no if_done_o; if_rdata_o unchanged; busy_o falls at cycle 5. A new fetch at cycle 5 completes normally at cycle 9.
- Reset asserted at cycle 2 of a DM read:
  - Response: all outputs 0 asynchronously, state IDLE, no dm_done_o. A post-reset request completes with the uncontended latency.
- MEM_LAT=1 and MEM_LAT=15 sweeps:
  - Response: done_o at t+3 and t+17 respectively; lat_cnt has no wrap artefacts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the IF and DM ports.
// Each access runs through ISSUE, WAIT and DONE states, and an IF fetch can be killed by a branch flush.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              kill_q, kill_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              gnt, gnt_dm, kill_now;

  // DM wins from IDLE; in DONE only the port that did not just finish is eligible.
  always_comb begin
    gnt    = 1'b0;
    gnt_dm = 1'b0;
    if (state_q == S_IDLE) begin
      if (dm_req_i) begin
        gnt    = 1'b1;
        gnt_dm = 1'b1;
      end else if (if_req_i) begin
        gnt = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      if (owner_q) begin
        gnt = if_req_i;
      end else begin
        gnt    = dm_req_i;
        gnt_dm = dm_req_i;
      end
    end
  end

  assign kill_now = kill_q | (flush_i & ~owner_q &
                              ((state_q == S_ISSUE) | (state_q == S_WAIT)));

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    kill_d     = kill_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        lat_cnt_d = LAT;
        kill_d    = kill_now;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        kill_d    = kill_now;
        if (lat_cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (owner_q) begin
            if (!we_q) dm_rdata_d = mem_rdata_i;
            dm_done_d = 1'b1;
          end else if (!kill_now) begin
            if_rdata_d = mem_rdata_i;
            if_done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = gnt ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (gnt) begin
      owner_d = gnt_dm;
      addr_d  = gnt_dm ? dm_addr_i : if_addr_i;
      we_d    = gnt_dm & dm_we_i;
      wdata_d = gnt_dm ? dm_wdata_i : wdata_q;
      kill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      kill_q     <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      kill_q     <= kill_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_stall_o  = dm_req_i & ~dm_done_q;
  assign mem_en_o    = (state_q == S_ISSUE);
  assign mem_we_o    = (state_q == S_ISSUE) & owner_q & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single transactions, hand-written flush/contention/reset
// sequences, latency sweeps on MEM_LAT=1/15 instances, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        if_req_i = 0, flush_i = 0, dm_req_i = 0, dm_we_i = 0;
  logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, mem_rdata_i = 0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_done_o, if_stall_o, dm_done_o, dm_stall_o, mem_en_o, mem_we_o, busy_o, owner_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o), .flush_i(flush_i),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o), .dm_stall_o(dm_stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .owner_o(owner_o));

  // Latency-sweep instances; their memory data is a cycle-stamped pattern.
  logic        s_req1 = 0, s_req15 = 0, s_zero = 0;
  logic [31:0] s_zero32 = 0, s_rdata = 0;
  logic [31:0] s1_ifrd, s1_dmrd, s1_maddr, s1_mwd, s15_ifrd, s15_dmrd, s15_maddr, s15_mwd;
  logic        s1_ifd, s1_ifs, s1_dmd, s1_dms, s1_en, s1_we, s1_busy, s1_own;
  logic        s15_ifd, s15_ifs, s15_dmd, s15_dms, s15_en, s15_we, s15_busy, s15_own;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(s_req1), .if_addr_i(32'h100),
    .if_rdata_o(s1_ifrd), .if_done_o(s1_ifd), .if_stall_o(s1_ifs), .flush_i(s_zero),
    .dm_req_i(s_zero), .dm_we_i(s_zero), .dm_addr_i(s_zero32), .dm_wdata_i(s_zero32),
    .dm_rdata_o(s1_dmrd), .dm_done_o(s1_dmd), .dm_stall_o(s1_dms),
    .mem_en_o(s1_en), .mem_we_o(s1_we), .mem_addr_o(s1_maddr), .mem_wdata_o(s1_mwd),
    .mem_rdata_i(s_rdata), .busy_o(s1_busy), .owner_o(s1_own));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_lat15 (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(s_req15), .if_addr_i(32'h200),
    .if_rdata_o(s15_ifrd), .if_done_o(s15_ifd), .if_stall_o(s15_ifs), .flush_i(s_zero),
    .dm_req_i(s_zero), .dm_we_i(s_zero), .dm_addr_i(s_zero32), .dm_wdata_i(s_zero32),
    .dm_rdata_o(s15_dmrd), .dm_done_o(s15_dmd), .dm_stall_o(s15_dms),
    .mem_en_o(s15_en), .mem_we_o(s15_we), .mem_addr_o(s15_maddr), .mem_wdata_o(s15_mwd),
    .mem_rdata_i(s_rdata), .busy_o(s15_busy), .owner_o(s15_own));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory stand-in: reads return data exactly L cycles after the command cycle, garbage otherwise.
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          cyc = 0, rd_cnt = 0;
  bit          rd_pend = 0;
  logic [31:0] rd_addr = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h01000193) ^ 32'h3C6EF372;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always begin
    @(posedge clk);
    #1;
    cyc++;
    s_rdata = {16'hC0DE, cyc[15:0]};
    if (rd_cnt > 0) rd_cnt--;
    if (rd_pend && rd_cnt == 0) begin
      mem_rdata_i = mem_m.exists(rd_addr) ? mem_m[rd_addr] : init_word(rd_addr);
      rd_pend     = 0;
    end else begin
      mem_rdata_i = $urandom();
    end
    if (mem_en_o) begin
      if (mem_we_o) begin
        mem_m[mem_addr_o] = mem_wdata_o;
      end else begin
        rd_pend = 1;
        rd_cnt  = L;
        rd_addr = mem_addr_o;
      end
    end
  end

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, {if_rdata_o, dm_rdata_o}, 64'h0);
    chk({tag, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'h0);
    chk({tag, "_ctl"}, {if_done_o, if_stall_o, dm_done_o, dm_stall_o, mem_en_o, mem_we_o, busy_o, owner_o}, 64'h0);
  endtask

  task automatic do_reset();
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0; flush_i = 0; s_req1 = 0; s_req15 = 0;
    rst_i = 1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  // Uncontended single transaction: command in cycle 1, done in cycle 2+L.
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        if (v.dm) begin
          dm_req_i = 1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
        end else begin
          if_req_i = 1; if_addr_i = v.addr;
        end
      end
      if (k == 5) begin if_req_i = 0; dm_req_i = 0; dm_we_i = 0; end
      @(negedge clk);
      chk("vec_en", mem_en_o, k == 1);
      if (k == 1) begin
        chk("vec_addr", mem_addr_o, v.addr);
        chk("vec_we", mem_we_o, v.we);
        if (v.we) chk("vec_wdata", mem_wdata_o, v.wdata);
      end
      chk("vec_done", v.dm ? dm_done_o : if_done_o, k == 4);
      chk("vec_other_done", v.dm ? if_done_o : dm_done_o, 0);
      chk("vec_stall", v.dm ? dm_stall_o : if_stall_o, k < 4);
      chk("vec_busy", busy_o, k >= 1 && k <= 4);
      if (k >= 1 && k <= 4) chk("vec_owner", owner_o, v.dm);
      if (k == 4) chk("vec_rdata", v.dm ? dm_rdata_o : if_rdata_o, v.exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic flush_seq(input logic dm, input logic [31:0] addr, input int fk,
                           input logic exp_done, input logic [31:0] exp_rd, input logic [31:0] prev_rd);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        if (dm) begin dm_req_i = 1; dm_we_i = 0; dm_addr_i = addr; end
        else begin if_req_i = 1; if_addr_i = addr; end
      end
      if (k == 5) begin if_req_i = 0; dm_req_i = 0; end
      flush_i = (k == fk);
      @(negedge clk);
      chk("fl_done", dm ? dm_done_o : if_done_o, exp_done && k == 4);
      chk("fl_other_done", dm ? if_done_o : dm_done_o, 0);
      if (k == 4) chk("fl_rdata", dm ? dm_rdata_o : if_rdata_o, exp_done ? exp_rd : prev_rd);
      chk("fl_busy", busy_o, k >= 1 && k <= 4);
      @(posedge clk); #1;
    end
    flush_i = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit if_act, dm_act, dm_w, legal;
    int if_start, dm_start, lat;
    logic [31:0] if_a, dm_a, dm_wd, exp_if_rd, exp_dm_rd;

    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'h2002000A};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h11223344};
    vecs[2] = '{1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 32'h11223344};
    vecs[3] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D};
    mem_m[32'h40] = 32'h2002000A;
    mem_m[32'h10] = 32'h11223344;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both ports at once: DM first, IF handed the grant in DM's DONE cycle.
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h10;
        if_req_i = 1; if_addr_i = 32'h10;
      end
      if (k == 5) dm_req_i = 0;
      if (k == 9) if_req_i = 0;
      @(negedge clk);
      chk("arb_en", mem_en_o, k == 1 || k == 5);
      if (k == 1 || k == 5) chk("arb_owner_at_en", owner_o, k == 1);
      chk("arb_dm_done", dm_done_o, k == 4);
      chk("arb_if_done", if_done_o, k == 8);
      chk("arb_if_stall", if_stall_o, k < 8);
      chk("arb_dm_stall", dm_stall_o, k < 4);
      chk("arb_busy", busy_o, k >= 1 && k <= 8);
      if (k == 4) chk("arb_dm_rdata", dm_rdata_o, 32'h11223344);
      chk("arb_if_rdata", if_rdata_o, (k >= 8) ? 32'h11223344 : 32'hCAFEF00D);
      @(posedge clk); #1;
    end

    // Fetch killed by flush in WAIT, then a fresh fetch at cycle 5.
    for (int k = 0; k < 11; k++) begin
      if (k == 0) begin if_req_i = 1; if_addr_i = 32'h08; end
      flush_i = (k == 2);
      if (k == 3) if_req_i = 0;
      if (k == 5) begin if_req_i = 1; if_addr_i = 32'h40; end
      if (k == 10) if_req_i = 0;
      @(negedge clk);
      chk("kill_done", if_done_o, k == 9);
      chk("kill_rdata", if_rdata_o, (k >= 9) ? 32'hCAFEF00D : 32'h11223344);
      chk("kill_busy", busy_o, (k >= 1 && k <= 4) || (k >= 6 && k <= 9));
      chk("kill_en", mem_en_o, k == 1 || k == 6);
      @(posedge clk); #1;
    end

    flush_seq(1'b1, 32'h08, 2, 1'b1, 32'hDEADBEEF, 32'h11223344);
    flush_seq(1'b0, 32'h08, 4, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
    flush_seq(1'b0, 32'h10, 3, 1'b0, 32'h0, 32'hDEADBEEF);
    flush_seq(1'b0, 32'h10, 1, 1'b0, 32'h0, 32'hDEADBEEF);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances.
    base = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin s_req1 = 1; s_req15 = 1; end
      if (k == 4) s_req1 = 0;
      if (k == 18) s_req15 = 0;
      @(negedge clk);
      if (k == 0) base = cyc;
      chk("l1_en", s1_en, k == 1);
      chk("l15_en", s15_en, k == 1);
      chk("l1_done", s1_ifd, k == 3);
      chk("l15_done", s15_ifd, k == 17);
      chk("l15_busy", s15_busy, k >= 1 && k <= 17);
      if (k == 1) chk("l_addr", {s1_maddr, s15_maddr}, {32'h100, 32'h200});
      if (k == 3) chk("l1_rdata", s1_ifrd, {16'hC0DE, 16'(base + 2)});
      if (k == 17) chk("l15_rdata", s15_ifrd, {16'hC0DE, 16'(base + 16)});
      if (k == 3) chk("l_dm_side", {s1_dmrd, s15_dmrd, s1_mwd, s15_mwd, s1_dmd, s1_dms, s1_we, s1_own,
                                    s15_dmd, s15_dms, s15_we, s15_own, s1_ifs, s15_ifs},
                      {128'h0, 8'h0, 2'b01});
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a DM read.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h10;
    @(negedge clk); chk("rmid_en0", mem_en_o, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("rmid_en1", mem_en_o, 1);
    @(posedge clk); #2;
    rst_i = 1; dm_req_i = 0;
    #1; chk_zero("rmid_async");
    @(negedge clk); chk_zero("rmid_c2");
    @(posedge clk); #1;
    @(negedge clk); chk_zero("rmid_c3");
    @(posedge clk); #1;
    rst_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmid_after", {dm_done_o, busy_o, dm_rdata_o}, 64'h0);
      @(posedge clk); #1;
    end
    run_vec('{1'b1, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF});

    // Randomized traffic against a transaction-level model.
    do_reset();
    if_act = 0; dm_act = 0; dm_w = 0; if_start = 0; dm_start = 0;
    if_a = 0; dm_a = 0; dm_wd = 0; exp_if_rd = 0; exp_dm_rd = 0;
    for (int k = 0; k < 800; k++) begin
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = 32'h100 + 32'($urandom_range(0, 15)) * 4; if_start = k;
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1; dm_a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        dm_w = 1'($urandom_range(0, 1)); dm_wd = $urandom(); dm_start = k;
      end
      if_req_i = if_act; if_addr_i = if_a;
      dm_req_i = dm_act; dm_we_i = dm_w & dm_act; dm_addr_i = dm_a; dm_wdata_i = dm_wd;
      @(negedge clk);
      if (mem_en_o) begin
        legal = (dm_act && mem_addr_o == dm_a && mem_we_o == dm_w && (!dm_w || mem_wdata_o == dm_wd)) ||
                (if_act && mem_addr_o == if_a && !mem_we_o);
        chk("rnd_cmd", legal, 1);
      end
      if (if_done_o) begin
        lat = k - if_start;
        chk("rnd_if_req", if_act, 1);
        chk("rnd_if_lat", (lat >= L + 2) && (lat <= 2 * L + 4), 1);
        exp_if_rd = ref_rd(if_a);
        chk("rnd_if_rdata", if_rdata_o, exp_if_rd);
        if_act = 0;
      end else begin
        chk("rnd_if_hold", if_rdata_o, exp_if_rd);
        if (if_act && (k - if_start) > 2 * L + 4) begin
          chk("rnd_if_timeout", k - if_start, 2 * L + 4);
          if_act = 0;
        end
      end
      if (dm_done_o) begin
        lat = k - dm_start;
        chk("rnd_dm_req", dm_act, 1);
        chk("rnd_dm_lat", (lat >= L + 2) && (lat <= 2 * L + 4), 1);
        if (dm_w) ref_mem[dm_a] = dm_wd;
        else exp_dm_rd = ref_rd(dm_a);
        chk("rnd_dm_rdata", dm_rdata_o, exp_dm_rd);
        dm_act = 0;
      end else begin
        chk("rnd_dm_hold", dm_rdata_o, exp_dm_rd);
        if (dm_act && (k - dm_start) > 2 * L + 4) begin
          chk("rnd_dm_timeout", k - dm_start, 2 * L + 4);
          dm_act = 0;
        end
      end
      @(posedge clk); #1;
    end
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
